// File: rtl/muldiv_iter_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small op-decoding helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULU = 2'b01,
    OP_DIV  = 2'b10,
    OP_DIVU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_unit_if.sv
// Handshake and operand/result bundle between CPU control and the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/muldiv_iter_unit_sign_fix.sv
// Combinational two's-complement conditioning: negates each half on its own,
// or the joined {x_hi,x_lo} as one 2*WIDTH value when joint is set.
module muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x_hi,
  input  logic [WIDTH-1:0] x_lo,
  input  logic             neg_hi,
  input  logic             neg_lo,
  input  logic             joint,
  output logic [WIDTH-1:0] y_hi,
  output logic [WIDTH-1:0] y_lo
);

  logic [2*WIDTH-1:0] joint_val;

  always_comb begin
    joint_val = {x_hi, x_lo};
    y_hi      = x_hi;
    y_lo      = x_lo;
    if (joint) begin
      // Product case: the 2*WIDTH value is negated as a whole, neg_lo carries its sign
      if (neg_lo) begin
        joint_val = -joint_val;
      end
      y_hi = joint_val[2*WIDTH-1:WIDTH];
      y_lo = joint_val[WIDTH-1:0];
    end else begin
      if (neg_hi) y_hi = -x_hi;
      if (neg_lo) y_lo = -x_lo;
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one step per cycle.
// Build option: define MULDIV_RADIX4_EN to retire two multiplier bits per cycle.
module muldiv_iter_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clock,
  input logic      clear,
  muldiv_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_DIV = CNT_W'(WIDTH - 1);
`ifdef MULDIV_RADIX4_EN
  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(WIDTH / 2 - 1);
`else
  localparam logic [CNT_W-1:0] LAST_MUL = CNT_W'(WIDTH - 1);
`endif

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   addend_q, addend_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div_zero_q, div_zero_d;
`ifdef MULDIV_RADIX4_EN
  logic [WIDTH+1:0]   addend3_q, addend3_d;
  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   mul_sum;
`else
  logic [WIDTH:0]     mul_sum;
`endif

  op_e              in_op;
  logic             in_signed;
  logic             in_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;

  assign in_op     = op_e'(bus.op);
  assign in_signed = op_is_signed(in_op);
  assign in_div    = op_is_div(in_op);

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
    .x_hi   (bus.a),
    .x_lo   (bus.b),
    .neg_hi (in_signed & bus.a[WIDTH-1]),
    .neg_lo (in_signed & bus.b[WIDTH-1]),
    .joint  (1'b0),
    .y_hi   (mag_a),
    .y_lo   (mag_b)
  );

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
    .x_hi   (acc_q[2*WIDTH-1:WIDTH]),
    .x_lo   (acc_q[WIDTH-1:0]),
    .neg_hi (rem_neg_q),
    .neg_lo (neg_q),
    .joint  (~op_is_div(op_q)),
    .y_hi   (res_hi),
    .y_lo   (res_lo)
  );

  // Multiply step: acc_hi accumulates, multiplier bits shift out of acc_lo
  always_comb begin
`ifdef MULDIV_RADIX4_EN
    unique case (acc_q[1:0])
      2'd0:    pp = '0;
      2'd1:    pp = {2'b00, addend_q};
      2'd2:    pp = {1'b0, addend_q, 1'b0};
      default: pp = addend3_q;
    endcase
    mul_sum  = {2'b00, acc_q[2*WIDTH-1:WIDTH]} + pp;
    mul_next = {mul_sum, acc_q[WIDTH-1:2]};
`else
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, addend_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
`endif
  end

  // Restoring divide step: acc_hi is the partial remainder, quotient bits enter acc_lo
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, addend_q};
    div_ge    = div_shift >= {1'b0, addend_q};
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    addend_d   = addend_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
`ifdef MULDIV_RADIX4_EN
    addend3_d  = addend3_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d      = in_op;
          cnt_d     = '0;
          neg_d     = in_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          rem_neg_d = in_signed & in_div & bus.a[WIDTH-1];
          addend_d  = in_div ? mag_b : mag_a;
`ifdef MULDIV_RADIX4_EN
          addend3_d = {2'b00, mag_a} + {1'b0, mag_a, 1'b0};
`endif
          if (in_div && bus.b == '0) begin
            // Divide-by-zero skips iteration; the result halves pass through unsigned
            dz_d      = 1'b1;
            neg_d     = 1'b0;
            rem_neg_d = 1'b0;
            acc_d     = {bus.a, {WIDTH{1'b1}}};
            state_d   = S_FIX;
          end else begin
            dz_d    = 1'b0;
            acc_d   = {{WIDTH{1'b0}}, (in_div ? mag_a : mag_b)};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = op_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == (op_is_div(op_q) ? LAST_DIV : LAST_MUL)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        hi_d       = res_hi;
        lo_d       = res_lo;
        div_zero_d = dz_q;
        state_d    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_ff @(posedge clock) begin
    op_q      <= op_d;
    addend_q  <= addend_d;
    acc_q     <= acc_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
    dz_q      <= dz_d;
`ifdef MULDIV_RADIX4_EN
    addend3_q <= addend3_d;
`endif
  end

  assign bus.busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done     = (state_q == S_DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Self-checking bench for muldiv_iter_unit: directed vector table, randomized
// operations against an arithmetic reference model, and handshake corner cases.
module tb_muldiv_iter_unit;

  localparam int W = 32;
`ifdef MULDIV_RADIX4_EN
  localparam int LAT_MUL = W / 2 + 2;
`else
  localparam int LAT_MUL = W + 2;
`endif
  localparam int LAT_DIV = W + 2;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   failures = 0;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_iter_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, truncating division
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output logic dz, output int lat);
    logic signed [63:0] sa, sb, p;
    logic        [63:0] ua, ub, up;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    lat = (op[1] == 1'b0) ? LAT_MUL : LAT_DIV;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dz = 1'b1; lat = 2;
        end else if (op == 2'b11) begin
          up = ua / ub; lo = up[31:0];
          up = ua % ub; hi = up[31:0];
        end else begin
          p = sa / sb; lo = p[31:0];
          p = sa % sb; hi = p[31:0];
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic dz, output int lat, output logic busy_ok);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    hi = '0; lo = '0; dz = 1'b0; lat = 0; busy_ok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.a = $urandom;
        bus.b = $urandom;
      end
      if (bus.done) begin
        lat = n; hi = bus.hi; lo = bus.lo; dz = bus.div_zero;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  task automatic do_check(input string tag, input vec_t v);
    logic [W-1:0] hi, lo;
    logic dz, bok;
    int lat;
    run_op(v.op, v.a, v.b, hi, lo, dz, lat, bok);
    check({tag, "_lat"}, 64'(lat), 64'(v.lat));
    check({tag, "_hi"}, 64'(hi), 64'(v.hi));
    check({tag, "_lo"}, 64'(lo), 64'(v.lo));
    check({tag, "_dz"}, 64'(dz), 64'(v.dz));
    check({tag, "_busy"}, 64'(bok), 64'(1));
  endtask

  vec_t vecs[10];

  initial begin
    logic [W-1:0] hi, lo, ra, rb;
    logic dz, bok;
    logic [1:0] rop;
    int lat, dones, sel;
    vec_t v;

    vecs[0] = '{2'b00, 32'hFFFFFFCB, 32'hFFFFFFC2, 32'h00000000, 32'h00000CD6, 1'b0, LAT_MUL};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT_MUL};
    vecs[2] = '{2'b10, 32'hFFFFFFCB, 32'h00000007, 32'hFFFFFFFC, 32'hFFFFFFF9, 1'b0, LAT_DIV};
    vecs[3] = '{2'b11, 32'h00000012, 32'h00000000, 32'h00000012, 32'hFFFFFFFF, 1'b1, 2};
    vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT_DIV};
    vecs[5] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, LAT_DIV};
    vecs[6] = '{2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 2};
    vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, LAT_MUL};
    vecs[8] = '{2'b00, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, LAT_MUL};
    vecs[9] = '{2'b10, 32'd53,       32'hFFFFFFF9, 32'd4,        32'hFFFFFFF9, 1'b0, LAT_DIV};

    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    check("rst_dz", 64'(bus.div_zero), 64'(0));

    foreach (vecs[i]) do_check($sformatf("vec%0d", i), vecs[i]);

    // Randomized operations, with biased corner operands
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = '0;
      else if (sel == 1) begin ra = 32'h80000000; rb = '1; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      v.op = rop; v.a = ra; v.b = rb;
      model(rop, ra, rb, v.hi, v.lo, v.dz, v.lat);
      do_check($sformatf("rnd%0d_op%0d", i, rop), v);
    end

    // Clear in mid-run aborts with no partial result
    v = vecs[1];
    run_op(v.op, v.a, v.b, hi, lo, dz, lat, bok);
    bus.op = 2'b00; bus.a = 32'h1234; bus.b = 32'h5678; bus.start = 1'b1;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #1 clear = 1'b1;
    @(posedge clock); #1 clear = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_hi", 64'(bus.hi), 64'(0));
    check("abort_lo", 64'(bus.lo), 64'(0));
    repeat (3) @(posedge clock);
    #1 check("abort_idle", 64'({bus.busy, bus.done}), 64'(0));
    do_check("after_abort", vecs[0]);

    // start held high, re-pulsed with new operands, still high in DONE
    bus.op = 2'b00; bus.a = 32'd1000; bus.b = 32'hFFFFFFFE; bus.start = 1'b1;
    dones = 0; hi = '0; lo = '0;
    for (int n = 1; n <= LAT_MUL + 4; n++) begin
      @(posedge clock); #1;
      if (n == 1) begin bus.a = 32'd7; bus.b = 32'd9; end
      if (n == 6) bus.op = 2'b11;
      if (bus.done) begin
        dones++; hi = bus.hi; lo = bus.lo;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("done_start_busy", 64'(bus.busy), 64'(0));
        check("done_start_done", 64'(bus.done), 64'(0));
        break;
      end
    end
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #1 check("hold_no_rerun", 64'({bus.busy, bus.done}), 64'(0));
    check("hold_dones", 64'(dones), 64'(1));
    check("hold_hi", 64'(hi), 64'(32'hFFFFFFFF));
    check("hold_lo", 64'(lo), 64'(32'hFFFFF830));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
